eprisc_fetch_unit: RTL and testbench

- Instruction fetch stage for the epRISC core. It sits directly upstream of the 256x32 embedded boot ROM, which has a synchronous read and a tri-stated data output gated by its enable.
- Holds the PC, drives the ROM address and enable, and captures returned words into a small prefetch queue.
- Delivers instructions and their PCs to decode over a valid/ready handshake; decode can redirect the PC on branches and jumps.

---
 rtl/eprisc_pkg.sv | 16 +
 rtl/eprisc_fetch_queue.sv | 51 +++++
 rtl/eprisc_fetch_unit.sv | 83 ++++++++
 tb/tb_eprisc_fetch_unit.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/eprisc_pkg.sv
// Shared types and constants for the epRISC front end.
package eprisc_pkg;

  localparam int INSTR_W    = 32;
  localparam int DEF_ADDR_W = 8;

  // Encoding decode can drop in as a bubble.
  localparam logic [INSTR_W-1:0] NOP = 32'h0400_0000;

  // Default fetch queue entry; the fetch unit passes its own width-matched type.
  typedef struct packed {
    logic [INSTR_W-1:0]    instr;
    logic [DEF_ADDR_W-1:0] pc;
  } fq_entry_t;

endpackage

// File: rtl/eprisc_fetch_queue.sv
// Small FIFO between ROM capture and decode. Flush wins over push.
module eprisc_fetch_queue
  import eprisc_pkg::*;
#(
  parameter int  QDEPTH  = 2,
  parameter type entry_t = fq_entry_t
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          push,
  input  entry_t                        push_data,
  input  logic                          pop,
  output entry_t                        head,
  output logic [$clog2(QDEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(QDEPTH);

  entry_t             mem [QDEPTH];
  logic [PTR_W-1:0]   rd_ptr, wr_ptr;

  function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(QDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Storage is not reset; the pointers alone define what is live.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy update; push and pop in one cycle both take effect.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= nxt(wr_ptr);
      if (pop)  rd_ptr <= nxt(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/eprisc_fetch_unit.sv
// Fetch stage: PC, ROM address/enable, prefetch queue, valid/ready to decode.
module eprisc_fetch_unit
  import eprisc_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int RESET_PC = 0,
  parameter int QDEPTH   = 2   // >= 2 for one instruction per cycle
) (
  input  logic               iClk,
  input  logic               iReset,
  output logic [ADDR_W-1:0]  oAddr,
  output logic               oRomEnable,
  input  logic [INSTR_W-1:0] iData,
  output logic [INSTR_W-1:0] oInstr,
  output logic [ADDR_W-1:0]  oInstrPC,
  output logic               oValid,
  input  logic               iReady,
  input  logic               iRedirect,
  input  logic [ADDR_W-1:0]  iRedirectPC
);

  localparam int CNT_W = $clog2(QDEPTH + 1);

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } entry_t;

  logic [ADDR_W-1:0] pc, inflight_pc;
  logic              inflight;
  logic [CNT_W-1:0]  count;
  logic [CNT_W:0]    occ;
  logic              pop, issue;
  entry_t            head, cap;

  assign pop = oValid && iReady;

  // Occupancy after this cycle's pop, counting the word already on its way.
  // Issuing only when that leaves room guarantees every returned word fits.
  always_comb begin
    occ   = {1'b0, count} + {{CNT_W{1'b0}}, inflight} - {{CNT_W{1'b0}}, pop};
    issue = !iRedirect && (occ < (CNT_W+1)'(QDEPTH));
  end

  // PC and in-flight tracking; redirect drops the word arriving next cycle.
  always_ff @(posedge iClk) begin
    if (iReset) begin
      pc          <= ADDR_W'(RESET_PC);
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (iRedirect) begin
      pc       <= iRedirectPC;
      inflight <= 1'b0;
    end else if (issue) begin
      pc          <= pc + 1'b1;
      inflight    <= 1'b1;
      inflight_pc <= pc;
    end else begin
      inflight <= 1'b0;
    end
  end

  assign cap = '{instr: iData, pc: inflight_pc};

  eprisc_fetch_queue #(.QDEPTH(QDEPTH), .entry_t(entry_t)) u_queue (
    .clk       (iClk),
    .rst       (iReset),
    .flush     (iRedirect),
    .push      (inflight),
    .push_data (cap),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  assign oAddr      = pc;
  assign oRomEnable = inflight;
  assign oValid     = (count != '0);
  // Zero while empty so the outputs are defined straight out of reset.
  assign oInstr     = oValid ? head.instr : '0;
  assign oInstrPC   = oValid ? head.pc    : '0;

endmodule

// File: tb/tb_eprisc_fetch_unit.sv
// Directed bench for the fetch unit against a 1-cycle synchronous ROM model.
module tb_eprisc_fetch_unit;

  logic        iClk = 1'b0;
  logic        iReset, iReady, iRedirect;
  logic [7:0]  iRedirectPC;
  logic [7:0]  oAddr, oInstrPC;
  logic        oRomEnable, oValid;
  logic [31:0] oInstr, rom_q;
  wire  [31:0] iData;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 iClk = ~iClk;

  eprisc_fetch_unit dut (
    .iClk        (iClk),
    .iReset      (iReset),
    .oAddr       (oAddr),
    .oRomEnable  (oRomEnable),
    .iData       (iData),
    .oInstr      (oInstr),
    .oInstrPC    (oInstrPC),
    .oValid      (oValid),
    .iReady      (iReady),
    .iRedirect   (iRedirect),
    .iRedirectPC (iRedirectPC)
  );

  // ROM: registered read of the address, driven only while enabled.
  always @(posedge iClk) rom_q <= 32'hA500_0000 | {24'h0, oAddr};
  assign iData = oRomEnable ? rom_q : 32'bz;

  typedef struct packed {
    logic       rst, rdy, rd;
    logic [7:0] tgt;
    logic       v;
    logic [7:0] pc, addr;
    logic       en;
  } vec_t;

  vec_t tbl[$];

  task automatic row(input logic rst, rdy, rd, input logic [7:0] tgt,
                     input logic v, input logic [7:0] pc, addr, input logic en);
    tbl.push_back('{rst, rdy, rd, tgt, v, pc, addr, en});
  endtask

  task automatic chk(input string name, input logic [31:0] act, exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Occupancy bound, checked every cycle.
  always @(negedge iClk) begin
    if (iReset === 1'b0) begin
      n_chk++;
      assert (dut.u_queue.count <= 2)
      else begin
        n_fail++;
        $display("FAIL queue_count: got %0d expected <= 2", dut.u_queue.count);
      end
    end
  end

  initial begin
    int k;
    iReset = 1'b1; iReady = 1'b1; iRedirect = 1'b0; iRedirectPC = '0;

    //   rst rdy rd tgt     | v  pc     addr   en
    row(0, 1, 0, 8'h00,   0, 8'h00, 8'h00, 0);  // c0
    row(0, 1, 0, 8'h00,   0, 8'h00, 8'h01, 1);
    row(0, 1, 0, 8'h00,   1, 8'h00, 8'h02, 1);
    row(0, 1, 0, 8'h00,   1, 8'h01, 8'h03, 1);
    row(0, 1, 0, 8'h00,   1, 8'h02, 8'h04, 1);
    row(0, 0, 0, 8'h00,   1, 8'h03, 8'h05, 1);  // c5 stall begins
    row(0, 0, 0, 8'h00,   1, 8'h03, 8'h05, 0);
    row(0, 0, 0, 8'h00,   1, 8'h03, 8'h05, 0);
    row(0, 0, 0, 8'h00,   1, 8'h03, 8'h05, 0);
    row(0, 0, 0, 8'h00,   1, 8'h03, 8'h05, 0);
    row(0, 1, 0, 8'h00,   1, 8'h03, 8'h05, 0);  // c10 release
    row(0, 1, 0, 8'h00,   1, 8'h04, 8'h06, 1);
    row(0, 1, 1, 8'h40,   1, 8'h05, 8'h07, 1);  // c12 redirect + handshake, 6 in flight
    row(0, 1, 0, 8'h00,   0, 8'h00, 8'h40, 0);
    row(0, 1, 0, 8'h00,   0, 8'h00, 8'h41, 1);
    row(0, 1, 0, 8'h00,   1, 8'h40, 8'h42, 1);
    row(0, 1, 1, 8'hFE,   1, 8'h41, 8'h43, 1);  // c16 redirect near wrap
    row(0, 1, 0, 8'h00,   0, 8'h00, 8'hFE, 0);
    row(0, 1, 0, 8'h00,   0, 8'h00, 8'hFF, 1);
    row(0, 1, 0, 8'h00,   1, 8'hFE, 8'h00, 1);
    row(0, 1, 0, 8'h00,   1, 8'hFF, 8'h01, 1);
    row(0, 1, 0, 8'h00,   1, 8'h00, 8'h02, 1);
    row(0, 1, 0, 8'h00,   1, 8'h01, 8'h03, 1);
    row(0, 1, 1, 8'h10,   1, 8'h02, 8'h04, 1);  // c23 back-to-back redirects
    row(0, 1, 1, 8'h20,   0, 8'h00, 8'h10, 0);
    row(0, 1, 0, 8'h00,   0, 8'h00, 8'h20, 0);
    row(0, 1, 0, 8'h00,   0, 8'h00, 8'h21, 1);
    row(0, 1, 1, 8'h22,   1, 8'h20, 8'h22, 1);  // c27 redirect to current PC
    row(0, 1, 0, 8'h00,   0, 8'h00, 8'h22, 0);
    row(0, 1, 0, 8'h00,   0, 8'h00, 8'h23, 1);

    repeat (3) @(posedge iClk);
    @(negedge iClk);
    chk("reset valid",   {31'b0, oValid},     32'd0);
    chk("reset romen",   {31'b0, oRomEnable}, 32'd0);
    chk("reset addr",    {24'b0, oAddr},      32'd0);
    chk("reset instr",   oInstr,              32'd0);
    chk("reset instrpc", {24'b0, oInstrPC},   32'd0);

    foreach (tbl[i]) begin
      @(negedge iClk);
      chk($sformatf("c%0d valid", i), {31'b0, oValid},     {31'b0, tbl[i].v});
      chk($sformatf("c%0d addr", i),  {24'b0, oAddr},      {24'b0, tbl[i].addr});
      chk($sformatf("c%0d romen", i), {31'b0, oRomEnable}, {31'b0, tbl[i].en});
      if (tbl[i].v) begin
        chk($sformatf("c%0d pc", i),    {24'b0, oInstrPC}, {24'b0, tbl[i].pc});
        chk($sformatf("c%0d instr", i), oInstr, 32'hA500_0000 | {24'b0, tbl[i].pc});
      end
      iReset = tbl[i].rst; iReady = tbl[i].rdy;
      iRedirect = tbl[i].rd; iRedirectPC = tbl[i].tgt;
    end

    // Mid-stream reset: 22 at the head, 23 in flight, decode stalled.
    @(negedge iClk);
    chk("mr head pc", {24'b0, oInstrPC},   32'h22);
    chk("mr romen",   {31'b0, oRomEnable}, 32'd1);
    iReady = 1'b0; iReset = 1'b1; iRedirect = 1'b0;
    @(negedge iClk);
    chk("mr valid",   {31'b0, oValid},     32'd0);
    chk("mr addr",    {24'b0, oAddr},      32'd0);
    chk("mr romen0",  {31'b0, oRomEnable}, 32'd0);
    iReset = 1'b0; iReady = 1'b1;

    // First delivery must land two cycles after release, with no stale word.
    k = 0;
    while (!oValid && k < 10) begin
      @(negedge iClk);
      k++;
    end
    chk("mr latency", k, 2);
    chk("mr first pc",    {24'b0, oInstrPC}, 32'h00);
    chk("mr first instr", oInstr,            32'hA500_0000);
    @(negedge iClk);
    chk("mr second pc",   {24'b0, oInstrPC}, 32'h01);
    chk("mr second v",    {31'b0, oValid},   32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
